axil_uart_lite: RTL and testbench

//  AXI4-Lite slave UART, register-compatible with the Xilinx AXI UART Lite (RX/TX/STAT/CTRL).

---
 rtl/axil_uart_lite.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_axil_uart_lite.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_uart_lite.sv
// rtl/axil_uart_lite.sv - AXI4-Lite UART with TX/RX FIFOs, Xilinx UART Lite register map
// Optional UART_PARITY_EN switches the frame from 8N1 to 8E1.
module axil_uart_lite #(
    parameter int CLK_FREQ_HZ = 250000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic        rx,
    output logic        tx,
    output logic        interrupt
);

    localparam int BIT_DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_LAST  = 16'(BIT_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BIT_DIV / 2 - 1);
    localparam logic [AW:0] PTR_ONE   = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } uart_state_t;

    logic live;
    logic aw_held, w_held, wr_strb0;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic wr_do, wr_en, ctrl_wr, tx_push, tx_drop, tx_flush, rx_flush;
    logic rd_acc, rx_pop, stat_clr;
    logic [1:0] rd_sel;
    logic [31:0] rd_val;
    logic [7:0] stat;
    logic intr_en, overrun, frame_err, parity_err;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp;
    logic        tx_empty, tx_full, tx_pop, tx_drain;
    logic [7:0]  tx_rd_data;
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp, rx_rp;
    logic        rx_empty, rx_full, rx_push;
    logic [7:0]  rx_rd_data;

    uart_state_t tx_state, tx_state_d, rx_state, rx_state_d;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_idx, rx_idx;
    logic [7:0]  tx_shreg, rx_shreg;
    logic        tx_done, rx_done;
    logic        rx_s1, rx_s2, rx_s3, rx_fall;
    logic        rx_push_req, rx_frame_bad;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_wdata[31:8],
                           s_axi_wstrb[3:1], s_axi_araddr[31:4], s_axi_araddr[1:0]};

    // Keeps every ready low until the first clock after reset release.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) live <= 1'b0;
        else                live <= 1'b1;
    end

    assign s_axi_awready = live && !s_axi_bvalid && !aw_held;
    assign s_axi_wready  = live && !s_axi_bvalid && !w_held;
    assign s_axi_arready = live && !s_axi_rvalid;
    assign s_axi_rresp   = 2'b00;

    assign wr_do    = aw_held && w_held;
    assign wr_en    = wr_do && wr_strb0;
    assign tx_push  = wr_en && (wr_addr == 2'd1) && !tx_full;
    assign tx_drop  = wr_en && (wr_addr == 2'd1) && tx_full;
    assign ctrl_wr  = wr_en && (wr_addr == 2'd3);
    assign tx_flush = ctrl_wr && wr_data[0];
    assign rx_flush = ctrl_wr && wr_data[1];

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            wr_addr      <= 2'd0;
            wr_data      <= 8'd0;
            wr_strb0     <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            intr_en      <= 1'b0;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                wr_addr <= s_axi_awaddr[3:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held   <= 1'b1;
                wr_data  <= s_axi_wdata[7:0];
                wr_strb0 <= s_axi_wstrb[0];
            end
            if (wr_do) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= tx_drop ? 2'b10 : 2'b00;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (ctrl_wr) intr_en <= wr_data[4];
        end
    end

    assign rd_acc   = s_axi_arvalid && s_axi_arready;
    assign rd_sel   = s_axi_araddr[3:2];
    assign rx_pop   = rd_acc && (rd_sel == 2'd0) && !rx_empty;
    assign stat_clr = rd_acc && (rd_sel == 2'd2);
    assign stat     = {parity_err, frame_err, overrun, intr_en, tx_full, tx_empty, rx_full, !rx_empty};

    always_comb begin
        rd_val = 32'd0;
        case (rd_sel)
            2'd0:    rd_val = rx_empty ? 32'd0 : {24'd0, rx_rd_data};
            2'd2:    rd_val = {24'd0, stat};
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= 32'd0;
        end else if (rd_acc) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_val;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    // FIFOs: pointers carry one extra wrap bit so full and empty are distinguishable.
    assign tx_empty   = (tx_wp == tx_rp);
    assign tx_full    = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_rd_data = tx_mem[tx_rp[AW-1:0]];
    assign rx_empty   = (rx_wp == rx_rp);
    assign rx_full    = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_rd_data = rx_mem[rx_rp[AW-1:0]];
    assign rx_push    = rx_push_req && (!rx_full || rx_pop);
    assign tx_drain   = tx_pop && !tx_push && !tx_flush && (tx_wp == tx_rp + PTR_ONE);

    always_ff @(posedge s_axi_aclk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wr_data;
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shreg;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_flush) begin
                tx_wp <= '0;
                tx_rp <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + PTR_ONE;
                if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            end
            if (rx_flush) begin
                rx_wp <= '0;
                rx_rp <= '0;
            end else begin
                if (rx_push) rx_wp <= rx_wp + PTR_ONE;
                if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            end
        end
    end

    assign tx_done = (tx_cnt == DIV_LAST);

    always_comb begin
        tx_state_d = tx_state;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_state_d = S_START;
            end
            S_START: if (tx_done) tx_state_d = S_DATA;
`ifdef UART_PARITY_EN
            S_DATA:   if (tx_done && tx_idx == 3'd7) tx_state_d = S_PARITY;
            S_PARITY: if (tx_done) tx_state_d = S_STOP;
`else
            S_DATA:   if (tx_done && tx_idx == 3'd7) tx_state_d = S_STOP;
`endif
            S_STOP:  if (tx_done) tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_idx   <= 3'd0;
            tx_shreg <= 8'd0;
        end else begin
            tx_state <= tx_state_d;
            if (tx_state == S_IDLE || tx_state_d != tx_state || tx_done) tx_cnt <= 16'd0;
            else                                                         tx_cnt <= tx_cnt + 16'd1;
            if (tx_pop) begin
                tx_shreg <= tx_rd_data;
                tx_idx   <= 3'd0;
            end else if (tx_state == S_DATA && tx_done) begin
                tx_shreg <= {1'b0, tx_shreg[7:1]};
                tx_idx   <= tx_idx + 3'd1;
            end
        end
    end

`ifdef UART_PARITY_EN
    logic tx_par, rx_par_bad;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)  tx_par <= 1'b0;
        else if (tx_pop)     tx_par <= ^tx_rd_data;
    end
`endif

    // Decoded from state so an async reset forces the line idle at once.
    always_comb begin
        tx = 1'b1;
        case (tx_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shreg[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx = tx_par;
`endif
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 && !rx_s2;
    assign rx_done = (rx_cnt == DIV_LAST);

    always_comb begin
        rx_state_d   = rx_state;
        rx_push_req  = 1'b0;
        rx_frame_bad = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad   = 1'b0;
`endif
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_state_d = S_START;
            S_START: if (rx_cnt == HALF_LAST) rx_state_d = rx_s2 ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
            S_DATA:  if (rx_done && rx_idx == 3'd7) rx_state_d = S_PARITY;
            S_PARITY: if (rx_done) begin
                rx_state_d = S_STOP;
                rx_par_bad = (rx_s2 != ^rx_shreg);
            end
`else
            S_DATA:  if (rx_done && rx_idx == 3'd7) rx_state_d = S_STOP;
`endif
            S_STOP: if (rx_done) begin
                rx_state_d   = S_IDLE;
                rx_frame_bad = !rx_s2;
                rx_push_req  = rx_s2;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rx_state <= S_IDLE;
            rx_cnt   <= 16'd0;
            rx_idx   <= 3'd0;
            rx_shreg <= 8'd0;
        end else begin
            rx_state <= rx_state_d;
            if (rx_state == S_IDLE || rx_state_d != rx_state || rx_done) rx_cnt <= 16'd0;
            else                                                         rx_cnt <= rx_cnt + 16'd1;
            if (rx_state == S_START) begin
                rx_idx <= 3'd0;
            end else if (rx_state == S_DATA && rx_done) begin
                rx_shreg <= {rx_s2, rx_shreg[7:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
        end
    end

    // A status-read clear loses to a same-cycle new error so no event is missed.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (stat_clr) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (rx_push_req && rx_full && !rx_pop) overrun <= 1'b1;
            if (rx_frame_bad) frame_err <= 1'b1;
            interrupt <= intr_en && ((rx_push && rx_empty && !rx_flush) || tx_drain);
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)  parity_err <= 1'b0;
        else if (rx_par_bad) parity_err <= 1'b1;
        else if (stat_clr)   parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_axil_uart_lite.sv
// tb/tb_axil_uart_lite.sv - directed self-checking bench for axil_uart_lite
module tb_axil_uart_lite;

    localparam int BD    = 16;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int LAST_RUN = 2 * BD;
`else
    localparam int LAST_RUN = BD;
`endif

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, tx, interrupt;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        loop_en = 1'b0, rx_drv = 1'b1, rx_in;
    int          n_asserts = 0, n_fails = 0, irq_cnt = 0;

    assign rx_in = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    always @(negedge clk) if (interrupt === 1'b1) irq_cnt++;

    axil_uart_lite #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .FIFO_DEPTH(DEPTH)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .rx(rx_in), .tx(tx), .interrupt(interrupt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        logic aw_go, w_go;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; n = 0;
        while ((awvalid || wvalid) && n < 100) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge clk);
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("write_addr_data_accepted", 32'(n < 100), 32'd1);
        bready = 1'b1; n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        check("write_response_seen", 32'(n < 100), 32'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0; n = 0;
        while (!rvalid && n < 100) begin @(negedge clk); n++; end
        check("read_response_seen", 32'(n < 100), 32'd1);
        d = rdata;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // kind: 0 good frame, 1 stop bit low, 2 wrong parity bit
    task automatic send_rx(input logic [7:0] b, input int kind);
        @(negedge clk);
        rx_drv = 1'b0; repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rx_drv = b[i]; repeat (BD) @(negedge clk); end
`ifdef UART_PARITY_EN
        rx_drv = (^b) ^ (kind == 2); repeat (BD) @(negedge clk);
`endif
        rx_drv = (kind != 1); repeat (BD) @(negedge clk);
        rx_drv = 1'b1; repeat (2 * BD) @(negedge clk);
    endtask

    task automatic tx_decode(output logic [7:0] b, output logic ok);
        int n;
        n = 0; b = 8'h00; ok = 1'b0;
        while (tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        if (n < 400) begin
            repeat (BD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin repeat (BD) @(negedge clk); b[i] = tx; end
`ifdef UART_PARITY_EN
            repeat (BD) @(negedge clk);
`endif
            repeat (BD) @(negedge clk);
            ok = (tx === 1'b1);
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [1:0]  resps [DEPTH + 2];
        logic [7:0]  got [DEPTH + 1];
        logic        okv [DEPTH + 1];
        logic [31:0] rd;
        logic        v;
        int          n, len, lows;

        repeat (3) @(negedge clk);
        check("reset_awready", 32'(awready), 32'd0);
        check("reset_wready", 32'(wready), 32'd0);
        check("reset_arready", 32'(arready), 32'd0);
        check("reset_bvalid", 32'(bvalid), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_bresp", 32'(bresp), 32'd0);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_interrupt", 32'(interrupt), 32'd0);
        aresetn = 1'b1;
        axi_read(32'h8, rd);
        check("stat_after_reset", rd, 32'h04);
        axi_read(32'h4, rd);
        check("tx_reg_reads_zero", rd, 32'h00);

        // 0x55 on the line: start, then alternating bits LSB first
        fork
            axi_write(32'h4, 32'h55, resp);
            begin
                n = 0;
                while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
                check("tx55_start_seen", 32'(n < 100), 32'd1);
                for (int r = 0; r < 9; r++) begin
                    v = tx; len = 0;
                    check($sformatf("tx55_run%0d_level", r), 32'(v), 32'(r % 2));
                    while (tx === v && len < 100) begin @(negedge clk); len++; end
                    check($sformatf("tx55_run%0d_cycles", r), len, (r == 8) ? LAST_RUN : BD);
                end
                check("tx55_stop_level", 32'(tx), 32'd1);
                repeat (BD - 1) @(negedge clk);
                check("tx55_stop_held", 32'(tx), 32'd1);
            end
        join
        check("tx55_bresp", 32'(resp), 32'd0);

        loop_en = 1'b1;
        axi_write(32'h4, 32'hA5, resp);
        repeat (14 * BD) @(negedge clk);
        axi_read(32'h8, rd);
        check("loop_stat_rx_valid", rd, 32'h05);
        axi_read(32'h0, rd);
        check("loop_rx_data", rd, 32'hA5);
        axi_read(32'h8, rd);
        check("loop_stat_after_pop", rd, 32'h04);
        axi_read(32'h0, rd);
        check("rx_read_empty", rd, 32'h00);
        loop_en = 1'b0;

        // DEPTH+2 writes: the first leaves the FIFO at once, so only the last is dropped
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++) axi_write(32'h4, 32'h10 + i, resps[i]);
                axi_read(32'h8, rd);
                check("stat_tx_full", rd, 32'h08);
            end
            for (int k = 0; k < DEPTH + 1; k++) tx_decode(got[k], okv[k]);
        join
        for (int i = 0; i < DEPTH + 2; i++)
            check($sformatf("burst_bresp%0d", i), 32'(resps[i]), (i == DEPTH + 1) ? 32'd2 : 32'd0);
        for (int k = 0; k < DEPTH + 1; k++) begin
            check($sformatf("burst_byte%0d", k), 32'(got[k]), 32'h10 + k);
            check($sformatf("burst_stop%0d", k), 32'(okv[k]), 32'd1);
        end
        lows = 0;
        repeat (20 * BD) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        check("no_extra_frame", lows, 0);

        for (int i = 0; i < DEPTH + 1; i++) send_rx(8'h31 + 8'(i), 0);
        axi_read(32'h8, rd);
        check("stat_overrun", rd, 32'h27);
        axi_read(32'h8, rd);
        check("stat_overrun_cleared", rd, 32'h07);
        axi_read(32'h0, rd);
        check("overrun_first_byte", rd, 32'h31);
        axi_write(32'hC, 32'h02, resp);
        axi_read(32'h8, rd);
        check("stat_after_rx_flush", rd, 32'h04);

        send_rx(8'h3C, 1);
        axi_read(32'h8, rd);
        check("stat_frame_err", rd, 32'h44);
        axi_read(32'h8, rd);
        check("stat_frame_err_cleared", rd, 32'h04);
`ifdef UART_PARITY_EN
        send_rx(8'h3C, 2);
        axi_read(32'h8, rd);
        check("stat_parity_err", rd, 32'h85);
        axi_read(32'h0, rd);
        check("parity_err_byte_kept", rd, 32'h3C);
`endif

        check("no_irq_while_disabled", irq_cnt, 0);
        axi_write(32'hC, 32'h10, resp);
        repeat (20) @(negedge clk);
        check("intr_en_no_pulse", irq_cnt, 0);
        send_rx(8'h5A, 0);
        check("irq_on_rx_valid", irq_cnt, 1);
        axi_read(32'h0, rd);
        check("irq_rx_data", rd, 32'h5A);
        axi_read(32'h8, rd);
        check("stat_intr_en", rd, 32'h14);
        axi_write(32'h4, 32'h33, resp);
        repeat (14 * BD) @(negedge clk);
        check("irq_on_tx_drain", irq_cnt, 2);

        axi_write(32'h4, 32'h00, resp);
        repeat (40) @(negedge clk);
        check("tx_low_mid_frame", 32'(tx), 32'd0);
        aresetn = 1'b0;
        #1;
        check("tx_high_async_reset", 32'(tx), 32'd1);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        axi_read(32'h8, rd);
        check("stat_after_mid_reset", rd, 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
